// File: rtl/ks_pkg.sv
// Shared definitions for the pipelined Kogge-Stone subtractor.
// With KS_SUB_FLAGS_EN defined, the S2 payload also carries the operand sign bits.
package ks_pkg;

  localparam int KS_SUPPORTED_VALENCY = 2;

  // Datapath width of the S2 payload; the subtractor's WIDTH must match it.
  localparam int KS_WIDTH = 8;

  function automatic int ks_levels(input int width);
    int levels;
    levels = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < width) begin
        levels = i + 1;
      end
    end
    return levels;
  endfunction

  typedef struct packed {
    logic [KS_WIDTH:0]   c;
    logic [KS_WIDTH-1:0] p;
`ifdef KS_SUB_FLAGS_EN
    logic                a_msb;
    logic                b_msb;
`endif
  } s2_payload_t;

endpackage

// File: rtl/ks_sub_prefix.sv
// Combinational radix-2 Kogge-Stone group-generate network.
// c[0] is the carry-in; c[i+1] is the carry out of bit i.
module ks_sub_prefix
  import ks_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int VALENCY = 2
) (
  input  logic [WIDTH-1:0] g,
  input  logic [WIDTH-1:0] p,
  input  logic             cin,
  output logic [WIDTH:0]   c
);

  localparam int LEVELS = ks_levels(WIDTH);

  if (VALENCY != KS_SUPPORTED_VALENCY) begin : g_bad_valency
    $error("ks_sub_prefix: only VALENCY = 2 is supported");
  end

  logic [LEVELS:0][WIDTH-1:0] gl;
  logic [LEVELS:0][WIDTH-1:0] pl;

  always_comb begin
    gl = '0;
    pl = '0;
    gl[0] = g;
    pl[0] = p;
    // Folding cin into bit 0 makes every group rooted at bit 0 complete.
    gl[0][0] = g[0] | (p[0] & cin);
    for (int l = 0; l < LEVELS; l++) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (i >= (1 << l)) begin
          gl[l+1][i] = gl[l][i] | (pl[l][i] & gl[l][i-(1<<l)]);
          pl[l+1][i] = pl[l][i] & pl[l][i-(1<<l)];
        end else begin
          gl[l+1][i] = gl[l][i];
          pl[l+1][i] = pl[l][i];
        end
      end
    end
    c = {gl[LEVELS], cin};
  end

endmodule

// File: rtl/ks_pipelined_subtractor.sv
// Three-stage Kogge-Stone subtractor D = A - B - Bin with borrow-out and valid/ready flow.
// Define KS_SUB_FLAGS_EN to add the Z/N/V status outputs aligned with D.
module ks_pipelined_subtractor
  import ks_pkg::*;
#(
  parameter int WIDTH   = KS_WIDTH,
  parameter int VALENCY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:1]   A,
  input  logic [WIDTH:1]   B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:1]   D,
  output logic             Bout
`ifdef KS_SUB_FLAGS_EN
  ,
  output logic             Z,
  output logic             N,
  output logic             V
`endif
);

  // Handshake: a beat moves across an interface on a rising edge where valid and
  // ready are both 1; valid never waits on ready, and in_ready depends only on
  // out_ready and the stage valid bits, never on in_valid.

  if (WIDTH != KS_WIDTH) begin : g_bad_width
    $error("ks_pipelined_subtractor: WIDTH must equal ks_pkg::KS_WIDTH");
  end
  if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_pow2
    $error("ks_pipelined_subtractor: WIDTH must be a power of two >= 2");
  end

  logic ld1, ld2, ld3;
  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;

  logic [WIDTH-1:0] g1_q, g1_d, p1_q, p1_d;
  logic             cin1_q, cin1_d;
`ifdef KS_SUB_FLAGS_EN
  logic             as1_q, as1_d, bs1_q, bs1_d;
  logic             z3_q, z3_d, n3_q, n3_d, ov3_q, ov3_d;
`endif

  logic [WIDTH:0]   c_pre;
  s2_payload_t      s2_q, s2_d;

  logic [WIDTH-1:0] d3_q, d3_d;
  logic             bout3_q, bout3_d;

  ks_sub_prefix #(
    .WIDTH   (WIDTH),
    .VALENCY (VALENCY)
  ) u_prefix (
    .g   (g1_q),
    .p   (p1_q),
    .cin (cin1_q),
    .c   (c_pre)
  );

  always_comb begin
    ld3 = !v3_q | out_ready;
    ld2 = !v2_q | ld3;
    ld1 = !v1_q | ld2;

    v1_d   = ld1 ? in_valid : v1_q;
    g1_d   = g1_q;
    p1_d   = p1_q;
    cin1_d = cin1_q;
`ifdef KS_SUB_FLAGS_EN
    as1_d  = as1_q;
    bs1_d  = bs1_q;
`endif
    // Data registers only move on real beats so bubbles leave D untouched.
    if (ld1 && in_valid) begin
      g1_d   = A & ~B;
      p1_d   = A ^ ~B;
      cin1_d = ~Bin;
`ifdef KS_SUB_FLAGS_EN
      as1_d  = A[WIDTH];
      bs1_d  = B[WIDTH];
`endif
    end

    v2_d = ld2 ? v1_q : v2_q;
    s2_d = s2_q;
    if (ld2 && v1_q) begin
      s2_d.c = c_pre;
      s2_d.p = p1_q;
`ifdef KS_SUB_FLAGS_EN
      s2_d.a_msb = as1_q;
      s2_d.b_msb = bs1_q;
`endif
    end

    v3_d    = ld3 ? v2_q : v3_q;
    d3_d    = d3_q;
    bout3_d = bout3_q;
`ifdef KS_SUB_FLAGS_EN
    z3_d    = z3_q;
    n3_d    = n3_q;
    ov3_d   = ov3_q;
`endif
    if (ld3 && v2_q) begin
      d3_d    = s2_q.p ^ s2_q.c[WIDTH-1:0];
      bout3_d = ~s2_q.c[WIDTH];
`ifdef KS_SUB_FLAGS_EN
      z3_d    = (d3_d == '0);
      n3_d    = d3_d[WIDTH-1];
      ov3_d   = (s2_q.a_msb ^ s2_q.b_msb) & (s2_q.a_msb ^ d3_d[WIDTH-1]);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      g1_q    <= '0;
      p1_q    <= '0;
      cin1_q  <= 1'b0;
      s2_q    <= '0;
      d3_q    <= '0;
      bout3_q <= 1'b0;
`ifdef KS_SUB_FLAGS_EN
      as1_q   <= 1'b0;
      bs1_q   <= 1'b0;
      z3_q    <= 1'b0;
      n3_q    <= 1'b0;
      ov3_q   <= 1'b0;
`endif
    end else begin
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      v3_q    <= v3_d;
      g1_q    <= g1_d;
      p1_q    <= p1_d;
      cin1_q  <= cin1_d;
      s2_q    <= s2_d;
      d3_q    <= d3_d;
      bout3_q <= bout3_d;
`ifdef KS_SUB_FLAGS_EN
      as1_q   <= as1_d;
      bs1_q   <= bs1_d;
      z3_q    <= z3_d;
      n3_q    <= n3_d;
      ov3_q   <= ov3_d;
`endif
    end
  end

  assign in_ready  = ld1;
  assign out_valid = v3_q;
  assign D         = d3_q;
  assign Bout      = bout3_q;
`ifdef KS_SUB_FLAGS_EN
  assign Z = z3_q;
  assign N = n3_q;
  assign V = ov3_q;
`endif

endmodule

// File: tb/tb_ks_pipelined_subtractor.sv
// Self-checking bench for ks_pipelined_subtractor (WIDTH = 8); Z/N/V are
// checked only when KS_SUB_FLAGS_EN is defined.
module tb_ks_pipelined_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a_i = '0;
  logic [7:0] b_i = '0;
  logic       bin_i = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] d_o;
  logic       bout_o;
`ifdef KS_SUB_FLAGS_EN
  logic       z_o, n_o, v_o;
`endif

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int accept_cyc = 0;

  // Expected entry layout: {v, n, z, bout, d[7:0]}.
  logic [11:0] exp_q[$];

  ks_pipelined_subtractor #(.WIDTH(8), .VALENCY(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a_i),
    .B         (b_i),
    .Bin       (bin_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (d_o),
    .Bout      (bout_o)
`ifdef KS_SUB_FLAGS_EN
    ,
    .Z         (z_o),
    .N         (n_o),
    .V         (v_o)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [11:0] model(input logic [7:0] a, input logic [7:0] b, input logic bin);
    int diff, sdiff;
    logic [7:0] d;
    logic bout, z, n, v;
    diff  = int'(a) - int'(b) - int'(bin);
    sdiff = int'($signed(a)) - int'($signed(b)) - int'(bin);
    d     = diff[7:0];
    bout  = (diff < 0);
    z     = (d == 8'h00);
    n     = d[7];
    v     = (sdiff > 127) || (sdiff < -128);
    return {v, n, z, bout, d};
  endfunction

  // ---------------- scoreboard / compare process ----------------
  logic       stall_seen = 1'b0;
  logic [7:0] held_d = '0;
  logic       held_bout = 1'b0;

  always @(negedge clk) begin
    logic [11:0] e;
    if (!rst_n) begin
      exp_q.delete();
      stall_seen = 1'b0;
    end else begin
      if (in_valid && in_ready) exp_q.push_back(model(a_i, b_i, bin_i));
      if (stall_seen && out_valid) begin
        check("stall_d_stable", {24'h0, d_o}, {24'h0, held_d});
        check("stall_bout_stable", {31'h0, bout_o}, {31'h0, held_bout});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("sb_d", {24'h0, d_o}, {24'h0, e[7:0]});
          check("sb_bout", {31'h0, bout_o}, {31'h0, e[8]});
`ifdef KS_SUB_FLAGS_EN
          check("sb_zflag", {31'h0, z_o}, {31'h0, e[9]});
          check("sb_nflag", {31'h0, n_o}, {31'h0, e[10]});
          check("sb_vflag", {31'h0, v_o}, {31'h0, e[11]});
`endif
        end
      end
      stall_seen = out_valid && !out_ready;
      held_d     = d_o;
      held_bout  = bout_o;
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic bin);
    int n;
    a_i = a;
    b_i = b;
    bin_i = bin;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) check("send_timeout", 32'd0, 32'd1);
    else accept_cyc = cyc;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [7:0] ed, input logic eb,
                            input logic ez, input logic en, input logic ev, input bit chk_lat);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    check({name, "_valid"}, {31'h0, out_valid}, 32'd1);
    if (chk_lat) check({name, "_latency"}, cyc - accept_cyc, 32'd3);
    check({name, "_d"}, {24'h0, d_o}, {24'h0, ed});
    check({name, "_bout"}, {31'h0, bout_o}, {31'h0, eb});
`ifdef KS_SUB_FLAGS_EN
    check({name, "_z"}, {31'h0, z_o}, {31'h0, ez});
    check({name, "_n"}, {31'h0, n_o}, {31'h0, en});
    check({name, "_v"}, {31'h0, v_o}, {31'h0, ev});
`else
    if (ez || en || ev) begin end
`endif
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc, ovc;
    bit rand_done;

    // Reset and post-reset state
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", {31'h0, out_valid}, 32'd0);
    check("rst_d", {24'h0, d_o}, 32'd0);
    check("rst_bout", {31'h0, bout_o}, 32'd0);
    check("rst_in_ready", {31'h0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Directed vectors with hand-computed results
    send(8'h05, 8'h03, 1'b0);
    expect_out("v05m03", 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send(8'h00, 8'h01, 1'b0);
    expect_out("v00m01", 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    send(8'h10, 8'h10, 1'b1);
    expect_out("v10m10b", 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    send(8'h80, 8'h01, 1'b0);
    expect_out("v80m01", 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    send(8'h3C, 8'h3C, 1'b0);
    expect_out("v3cm3c", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

    // Backpressure: only three beats fit, then drain one per cycle
    out_ready = 1'b0;
    acc = 0;
    a_i = 8'h20; b_i = 8'h07; bin_i = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      @(posedge clk);
      #1;
      a_i = 8'h20 + 8'(acc * 17);
      b_i = 8'h07 + 8'(acc * 5);
      bin_i = acc[0];
    end
    in_valid = 1'b0;
    check("bp_accepted", acc, 32'd3);
    @(negedge clk);
    check("bp_in_ready_full", {31'h0, in_ready}, 32'd0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    ovc = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (out_valid) ovc++;
    end
    check("bp_drain_back_to_back", ovc, 32'd3);
    @(negedge clk);
    check("bp_drained_empty", {31'h0, out_valid}, 32'd0);
    @(posedge clk);
    #1;

    // Random traffic: 50% in_valid, 50% out_ready
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          while ($urandom_range(0, 1) == 0) begin
            @(posedge clk);
            #1;
          end
          send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clk);
    #1;
    check("rand_all_drained", exp_q.size(), 32'd0);

    // Reset with three beats in flight
    out_ready = 1'b0;
    send(8'h11, 8'h01, 1'b0);
    send(8'h22, 8'h02, 1'b0);
    send(8'h33, 8'h03, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("mid_rst_out_valid", {31'h0, out_valid}, 32'd0);
    check("mid_rst_d", {24'h0, d_o}, 32'd0);
    check("mid_rst_bout", {31'h0, bout_o}, 32'd0);
    check("mid_rst_in_ready", {31'h0, in_ready}, 32'd1);
    ovc = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_valid) ovc++;
    end
    check("mid_rst_no_stale", ovc, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got stuck, expected completion");
    $fatal(1, "timeout");
  end

endmodule
